mac_sequencer: RTL and testbench
================================

# mac_sequencer

Control-side initiator for the MultAccumulate datapath. It walks the ROM A/B/C address space for a job of NUM_RESULTS result pairs and drives enable_mult, enable_sum and clear with timing that matches the datapath's 2-cycle enable pipeline. It samples finalResultA/B in the single cycle they are driven and writes each pair into a result RAM. It sits between the top-level job control and the ROM/MAC/result-RAM cluster.

## Interface
- DATA_WIDTH, 8: element width; informational, must match the datapath.
- RESULT_WIDTH, 24: width of finalResult inputs and of the result write data.
- BEATS, 4: enable_mult cycles (4-lane words) accumulated per result pair; ≥1.
- NUM_RESULTS, 8: result pairs per job; ≥1.
- ADDR_WIDTH, 6: ROM A/B address width; must be ≥ clog2(2·NUM_RESULTS·BEATS).

- clock  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- start  in  1  job request; sampled only in IDLE.
- busy  out  1  high whenever state ≠ IDLE.
- done  out  1  one-cycle pulse with the last result write.
- romAB_addrA  out  ADDR_WIDTH  ROM A and ROM B port-A address (shared).
- romAB_addrB  out  ADDR_WIDTH  ROM A and ROM B port-B address (shared).
- romC_addrA, romC_addrB  out  clog2(2·NUM_RESULTS)  ROM C addresses.
- enable_mult, enable_sum, clear  out  1  datapath controls.
- finalResultA, finalResultB  in  RESULT_WIDTH  datapath outputs; Z except when valid.
- res_we  out  1  result RAM write strobe.
- res_addr  out  clog2(NUM_RESULTS)  result RAM address.
- res_dataA, res_dataB  out  RESULT_WIDTH  captured results.

## Operation
- States: IDLE, MULT, SUM, WAIT, CAPTURE. Counters: beat b (0..BEATS-1), pair p (0..NUM_RESULTS-1).
- IDLE: b=p=0. start=1 → MULT.
- MULT: enable_mult=1 for BEATS consecutive cycles. romAB_addrA=(2p)·BEATS+b, romAB_addrB=(2p+1)·BEATS+b, romC_addrA=2p, romC_addrB=2p+1. At b=BEATS-1 → SUM.
- SUM: enable_sum=1 for one cycle → WAIT.
- WAIT: all controls 0 → CAPTURE.
- CAPTURE: finalResultA/B are valid this cycle. Register them into res_dataA/B, set res_addr=p, and assert clear=1.
  - If p<NUM_RESULTS-1: p++, b=0 → MULT.
  - Otherwise → IDLE.
- res_we is a registered, one-cycle strobe in the cycle after CAPTURE. done coincides with the final res_we.
- Control outputs are Moore decodes of the state register. Addresses come straight from the counters. Both are 0 outside their active states.
- finalResult inputs are never sampled outside CAPTURE. They are Z elsewhere.
- start outside IDLE is ignored. start in the cycle done is high is accepted, because the state is already IDLE.
- No arithmetic is performed on the results; widths pass through unchanged.

## Timing
- Reset: state IDLE, counters 0. busy, done, enable_mult, enable_sum, clear and res_we are 0. All addresses and res_data are 0.
- Reset mid-job aborts immediately. Nothing is written after reset; in-flight datapath enables are the datapath's concern.
- With start high in cycle 0: MULT occupies cycles 1..BEATS, SUM is cycle BEATS+1, WAIT is BEATS+2, CAPTURE is BEATS+3, first res_we is BEATS+4.
- Pair period is BEATS+3 cycles. The final done arrives in cycle NUM_RESULTS·(BEATS+3)+1.
- Alignment with the datapath: if the last enable_mult is in cycle t, enable_sum is in t+1 and the datapath output is valid in t+3, which is CAPTURE. clear in t+3 zeros the accumulators before the next pair's first accumulate at t+6.
- clear is never high in a cycle where the datapath's delayed enable_mult is high.

## Configuration
- MAC_SEQ_ABORT_EN defined:
  - Adds input abort (1 bit) and output aborted (1 bit).
  - abort in any non-IDLE state → DRAIN state. DRAIN holds clear=1 for 3 cycles to flush the enable pipeline, then goes to IDLE with a one-cycle aborted pulse.
  - During DRAIN, no res_we and no done.
  - abort in IDLE is ignored. reset has priority over abort.
- Undefined: no abort/aborted ports and no DRAIN state; jobs always run to completion.

## Structure
- Package mac_seq_pkg holds the state enum typedef (IDLE, MULT, SUM, WAIT, CAPTURE, and DRAIN under the macro) and a localparam function for the address-width check.
- Single module; no sub-module is needed. The counters and FSM stay inline.

## Test plan
- Defaults, single start, datapath model returning A=0x000123, B=0x000456 at CAPTURE → first res_we in cycle 8 with res_addr=0 and data 0x000123/0x000456. done in cycle 57, busy low in cycle 57.
- Address sweep with defaults → romAB_addrA runs 0,1,2,3 and romAB_addrB runs 4,5,6,7 for p=0. For p=7: 56..59 and 60..63. romC pairs (14,15) for p=7.
- Datapath driving X/Z outside valid cycles → res_data never contains X; exactly 8 writes, addresses 0..7 in order.
- start held high continuously → back-to-back jobs; second job's MULT begins in the cycle after done. start pulses mid-job are ignored.
- reset asserted in cycle 20 → next cycle all outputs 0 and IDLE. No res_we is issued until a new start.
- With MAC_SEQ_ABORT_EN, abort in cycle 10 → clear high in cycles 11–13, aborted pulse in cycle 14, no done, and only the writes already issued (cycle 8) are present.

Source files
------------

// File: rtl/mac_seq_pkg.sv
// Shared types and elaboration helpers for mac_sequencer.
// The DRAIN state exists only when MAC_SEQ_ABORT_EN is defined.
package mac_seq_pkg;

   typedef enum logic [2:0] {
      IDLE,
      MULT,
      SUM,
      WAIT,
      CAPTURE
`ifdef MAC_SEQ_ABORT_EN
      , DRAIN
`endif
   } mac_state_t;

   // Smallest ROM A/B address width able to cover one job's operands.
   function automatic int unsigned min_addr_width(input int unsigned num_results,
                                                  input int unsigned beats);
      return $clog2(2 * num_results * beats);
   endfunction

   // clog2 with a floor of one bit so degenerate sizes still give legal vectors.
   function automatic int unsigned width_min1(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/mac_sequencer.sv
// Control-side sequencer for the MultAccumulate datapath: walks ROM addresses,
// drives enables/clear and writes result pairs. Option: MAC_SEQ_ABORT_EN.
module mac_sequencer
   import mac_seq_pkg::*;
#(
   parameter int unsigned DATA_WIDTH   = 8,
   parameter int unsigned RESULT_WIDTH = 24,
   parameter int unsigned BEATS        = 4,
   parameter int unsigned NUM_RESULTS  = 8,
   parameter int unsigned ADDR_WIDTH   = 6
) (
   input  logic                                    clock,
   input  logic                                    reset,
`ifdef MAC_SEQ_ABORT_EN
   input  logic                                    abort,
   output logic                                    aborted,
`endif
   input  logic                                    start,
   output logic                                    busy,
   output logic                                    done,
   output logic [ADDR_WIDTH-1:0]                   romAB_addrA,
   output logic [ADDR_WIDTH-1:0]                   romAB_addrB,
   output logic [width_min1(2*NUM_RESULTS)-1:0]    romC_addrA,
   output logic [width_min1(2*NUM_RESULTS)-1:0]    romC_addrB,
   output logic                                    enable_mult,
   output logic                                    enable_sum,
   output logic                                    clear,
   input  logic [RESULT_WIDTH-1:0]                 finalResultA,
   input  logic [RESULT_WIDTH-1:0]                 finalResultB,
   output logic                                    res_we,
   output logic [width_min1(NUM_RESULTS)-1:0]      res_addr,
   output logic [RESULT_WIDTH-1:0]                 res_dataA,
   output logic [RESULT_WIDTH-1:0]                 res_dataB
);

   localparam int unsigned B_W   = width_min1(BEATS);
   localparam int unsigned RES_W = width_min1(NUM_RESULTS);
   localparam int unsigned RC_W  = width_min1(2 * NUM_RESULTS);

   if (DATA_WIDTH < 1 || BEATS < 1 || NUM_RESULTS < 1 ||
       ADDR_WIDTH < min_addr_width(NUM_RESULTS, BEATS)) begin : g_param_check
      $error("mac_sequencer: ADDR_WIDTH too small or zero-sized parameter");
   end

   mac_state_t       state, next_state;
   logic [B_W-1:0]   beat_q;
   logic [RES_W-1:0] pair_q;
   logic             last_beat, last_pair, capture_fire;

   assign last_beat = (beat_q == B_W'(BEATS - 1));
   assign last_pair = (pair_q == RES_W'(NUM_RESULTS - 1));

`ifdef MAC_SEQ_ABORT_EN
   logic [1:0] drain_q;
   logic       abort_take;

   assign abort_take   = abort && (state != IDLE) && (state != DRAIN);
   // An abort landing on CAPTURE must not produce a write.
   assign capture_fire = (state == CAPTURE) && !abort_take;
`else
   assign capture_fire = (state == CAPTURE);
`endif

   always_comb begin
      next_state  = state;
      enable_mult = 1'b0;
      enable_sum  = 1'b0;
      clear       = 1'b0;
      romAB_addrA = '0;
      romAB_addrB = '0;
      romC_addrA  = '0;
      romC_addrB  = '0;
      busy        = (state != IDLE);
      case (state)
         IDLE: begin
            if (start) next_state = MULT;
         end
         MULT: begin
            enable_mult = 1'b1;
            romAB_addrA = ADDR_WIDTH'((2 * 32'(pair_q)) * BEATS + 32'(beat_q));
            romAB_addrB = ADDR_WIDTH'((2 * 32'(pair_q) + 1) * BEATS + 32'(beat_q));
            romC_addrA  = RC_W'(2 * 32'(pair_q));
            romC_addrB  = RC_W'(2 * 32'(pair_q) + 1);
            if (last_beat) next_state = SUM;
         end
         SUM: begin
            enable_sum = 1'b1;
            next_state = WAIT;
         end
         WAIT: begin
            next_state = CAPTURE;
         end
         CAPTURE: begin
            clear      = 1'b1;
            next_state = last_pair ? IDLE : MULT;
         end
`ifdef MAC_SEQ_ABORT_EN
         DRAIN: begin
            clear = 1'b1;
            if (drain_q == 2'd2) next_state = IDLE;
         end
`endif
         default: next_state = IDLE;
      endcase
`ifdef MAC_SEQ_ABORT_EN
      if (abort_take) next_state = DRAIN;
`endif
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         beat_q    <= '0;
         pair_q    <= '0;
         res_we    <= 1'b0;
         done      <= 1'b0;
         res_addr  <= '0;
         res_dataA <= '0;
         res_dataB <= '0;
      end else begin
         state  <= next_state;
         res_we <= capture_fire;
         done   <= capture_fire && last_pair;
         if (capture_fire) begin
            res_addr  <= pair_q;
            res_dataA <= finalResultA;
            res_dataB <= finalResultB;
         end
         case (state)
            MULT:    beat_q <= last_beat ? '0 : beat_q + B_W'(1);
            CAPTURE: begin
               beat_q <= '0;
               pair_q <= last_pair ? '0 : pair_q + RES_W'(1);
            end
            SUM, WAIT: ;
            default: begin
               beat_q <= '0;
               pair_q <= '0;
            end
         endcase
`ifdef MAC_SEQ_ABORT_EN
         if (abort_take) begin
            beat_q <= '0;
            pair_q <= '0;
         end
`endif
      end
   end

`ifdef MAC_SEQ_ABORT_EN
   always_ff @(posedge clock) begin
      if (reset) begin
         drain_q <= '0;
         aborted <= 1'b0;
      end else begin
         drain_q <= (state == DRAIN) ? drain_q + 2'd1 : '0;
         aborted <= (state == DRAIN) && (next_state == IDLE);
      end
   end
`endif

endmodule

// File: tb/tb_mac_sequencer.sv
// Scoreboard bench for mac_sequencer with a small datapath model (2-cycle
// enable pipeline) and directed jobs: single, back-to-back, reset, abort.
module tb_mac_sequencer;

   localparam int BEATS    = 4;
   localparam int NR       = 8;
   localparam int AW       = 6;
   localparam int RW       = 24;
   localparam int PERIOD   = BEATS + 3;
   localparam int DONE_OFF = NR * PERIOD + 1;

   logic          clock = 1'b0;
   logic          reset, start;
   logic          busy, done, enable_mult, enable_sum, clear, res_we;
   logic [AW-1:0] romAB_addrA, romAB_addrB;
   logic [3:0]    romC_addrA, romC_addrB;
   logic [RW-1:0] finalResultA, finalResultB, res_dataA, res_dataB;
   logic [2:0]    res_addr;
`ifdef MAC_SEQ_ABORT_EN
   logic          abort, aborted;
`endif

   mac_sequencer #(.DATA_WIDTH(8), .RESULT_WIDTH(RW), .BEATS(BEATS),
                   .NUM_RESULTS(NR), .ADDR_WIDTH(AW)) dut (
      .clock(clock), .reset(reset),
`ifdef MAC_SEQ_ABORT_EN
      .abort(abort), .aborted(aborted),
`endif
      .start(start), .busy(busy), .done(done),
      .romAB_addrA(romAB_addrA), .romAB_addrB(romAB_addrB),
      .romC_addrA(romC_addrA), .romC_addrB(romC_addrB),
      .enable_mult(enable_mult), .enable_sum(enable_sum), .clear(clear),
      .finalResultA(finalResultA), .finalResultB(finalResultB),
      .res_we(res_we), .res_addr(res_addr),
      .res_dataA(res_dataA), .res_dataB(res_dataB));

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc = cyc + 1;

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Datapath model: output valid two cycles after enable_sum, Z or X otherwise.
   logic sum_d1 = 1'b0, sum_d2 = 1'b0, x_mode = 1'b0;
   int   k = 0;
   always @(posedge clock) begin
      sum_d1 <= enable_sum;
      sum_d2 <= sum_d1;
      if (sum_d2) k <= k + 1;
   end

   function automatic logic [RW-1:0] val_a(input int kk);
      return 24'h000123 + 24'(kk) * 24'h001001;
   endfunction
   function automatic logic [RW-1:0] val_b(input int kk);
      return 24'h000456 + 24'(kk) * 24'h010101;
   endfunction

   assign finalResultA = sum_d2 ? val_a(k) : (x_mode ? 'x : 'z);
   assign finalResultB = sum_d2 ? val_b(k) : (x_mode ? 'x : 'z);

   typedef struct {
      int         cyc;
      logic [2:0] addr;
      logic [RW-1:0] a;
      logic [RW-1:0] b;
      logic       last;
   } exp_t;
   exp_t sb[$];
   exp_t mon_e;

   always @(negedge clock) begin
      if (res_we === 1'b1) begin
         if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_write: got addr %0d expected no write (cycle %0d)", res_addr, cyc);
         end else begin
            mon_e = sb.pop_front();
            check("wr_cycle", 64'(cyc), 64'(mon_e.cyc));
            check("wr_addr", 64'(res_addr), 64'(mon_e.addr));
            check("wr_dataA", 64'(res_dataA), 64'(mon_e.a));
            check("wr_dataB", 64'(res_dataB), 64'(mon_e.b));
            check("wr_done", 64'(done), 64'(mon_e.last));
         end
      end else if (done !== 1'b0) begin
         check("done_without_write", 64'(done), 64'd0);
      end
   end

   // Control-pattern model: position within the job from cycle offset alone.
   logic job_active = 1'b0;
   int   job_c0 = 0;
   int   rel, r, p;
   always @(negedge clock) begin
      if (job_active) begin
         rel = cyc - job_c0;
         if (rel >= 1 && rel <= NR * PERIOD) begin
            r = (rel - 1) % PERIOD;
            p = (rel - 1) / PERIOD;
            check("busy", 64'(busy), 64'd1);
            check("enable_mult", 64'(enable_mult), 64'(r < BEATS));
            check("enable_sum", 64'(enable_sum), 64'(r == BEATS));
            check("clear", 64'(clear), 64'(r == BEATS + 2));
            if (r < BEATS) begin
               check("romAB_addrA", 64'(romAB_addrA), 64'(8 * p + r));
               check("romAB_addrB", 64'(romAB_addrB), 64'(8 * p + 4 + r));
               check("romC_addrA", 64'(romC_addrA), 64'(2 * p));
               check("romC_addrB", 64'(romC_addrB), 64'(2 * p + 1));
            end else begin
               check("romAB_idle", 64'({romAB_addrA, romAB_addrB, romC_addrA, romC_addrB}), 64'd0);
            end
         end
      end
   end

   task automatic step();
      @(posedge clock);
      #2;
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) step();
   endtask

   task automatic push_job(input int c0, input int kstart, input int count);
      exp_t e;
      for (int a = 0; a < count; a++) begin
         e.cyc  = c0 + BEATS + 4 + PERIOD * a;
         e.addr = 3'(a);
         e.a    = val_a(kstart + a);
         e.b    = val_b(kstart + a);
         e.last = (a == NR - 1);
         sb.push_back(e);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_ctrl"}, 64'({busy, done, enable_mult, enable_sum, clear, res_we}), 64'd0);
      check({tag, "_addr"}, 64'({romAB_addrA, romAB_addrB, romC_addrA, romC_addrB, res_addr}), 64'd0);
      check({tag, "_data"}, 64'({res_dataA, res_dataB}), 64'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion (cycle %0d)", cyc);
      $fatal(1, "watchdog expired");
   end

   int c0, kst;
   initial begin
      reset = 1'b1;
      start = 1'b0;
`ifdef MAC_SEQ_ABORT_EN
      abort = 1'b0;
`endif
      repeat (3) step();
      check_all_zero("reset");
      reset = 1'b0;
      repeat (2) step();

      // Single job, with stray start pulses mid-job.
      c0 = cyc; kst = k;
      push_job(c0, kst, NR);
      job_c0 = c0; job_active = 1'b1;
      start = 1'b1; step(); start = 1'b0;
      wait_until(c0 + 20); start = 1'b1; step(); start = 1'b0;
      wait_until(c0 + 33); start = 1'b1; step(); start = 1'b0;
      wait_until(c0 + DONE_OFF);
      check("job1_busy_low", 64'(busy), 64'd0);
      check("job1_done", 64'(done), 64'd1);
      job_active = 1'b0;
      repeat (3) step();
      check("job1_drained", 64'(sb.size()), 64'd0);

      // Back-to-back jobs with start held; datapath drives X when not valid.
      x_mode = 1'b1;
      c0 = cyc; kst = k;
      push_job(c0, kst, NR);
      job_c0 = c0; job_active = 1'b1;
      start = 1'b1;
      wait_until(c0 + DONE_OFF);
      check("b2b_idle_at_done", 64'(busy), 64'd0);
      push_job(c0 + DONE_OFF, kst + NR, NR);
      job_c0 = c0 + DONE_OFF;
      step();
      start = 1'b0;
      wait_until(job_c0 + DONE_OFF);
      check("job3_busy_low", 64'(busy), 64'd0);
      job_active = 1'b0;
      x_mode = 1'b0;
      repeat (3) step();
      check("b2b_drained", 64'(sb.size()), 64'd0);

      // Reset in cycle 20 of a job.
      c0 = cyc; kst = k;
      push_job(c0, kst, 2);
      job_c0 = c0; job_active = 1'b1;
      start = 1'b1; step(); start = 1'b0;
      wait_until(c0 + 20);
      job_active = 1'b0;
      reset = 1'b1; step(); reset = 1'b0;
      check_all_zero("midreset");
      repeat (20) step();
      check("midreset_idle", 64'(busy), 64'd0);
      check("midreset_drained", 64'(sb.size()), 64'd0);

`ifdef MAC_SEQ_ABORT_EN
      abort = 1'b1; step(); abort = 1'b0;
      check("abort_idle_ignored", 64'({busy, aborted}), 64'd0);
      c0 = cyc; kst = k;
      push_job(c0, kst, 1);
      start = 1'b1; step(); start = 1'b0;
      wait_until(c0 + 10);
      abort = 1'b1; step(); abort = 1'b0;
      for (int i = 11; i <= 13; i++) begin
         check("drain_clear", 64'({clear, busy, aborted, enable_mult, enable_sum}), 64'b11000);
         step();
      end
      check("aborted_pulse", 64'({aborted, busy, clear}), 64'b100);
      step();
      check("aborted_once", 64'(aborted), 64'd0);
      repeat (15) step();
      check("abort_drained", 64'(sb.size()), 64'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
